// File: rtl/muldiv_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_seq_ctrl: sequential 8x8 unsigned multiply / restoring divide      |
// | around one shared 8-bit adder. Divide path enabled by macro DIV_EN.       |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module muldiv_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_hi,
  output logic [7:0] result_lo,
  output logic       dbz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mq_q, mq_d;
  logic [7:0] m_q, m_d;
  logic [7:0] res_hi_q, res_hi_d;
  logic [7:0] res_lo_q, res_lo_d;
  logic       dbz_q, dbz_d;

  logic [7:0] add_a, add_b;
  logic       add_ci;
  logic [8:0] add_s;
  logic [8:0] mul_part;
  logic [7:0] step_acc, step_mq;
  logic       div_zero;

`ifdef DIV_EN
  logic       op_q, op_d;
  logic [7:0] r_shift;

  // {R,Q} shifted left once; the bit shifted out of R is acc_q[7]
  assign r_shift  = {acc_q[6:0], mq_q[7]};
  assign div_zero = op_q && (m_q == 8'd0);
`else
  logic unused_op;

  assign unused_op = op;
  assign div_zero  = 1'b0;
`endif

  always_comb begin
    add_a  = acc_q;
    add_b  = m_q;
    add_ci = 1'b0;
`ifdef DIV_EN
    if (op_q) begin
      add_a  = r_shift;
      add_ci = 1'b1;
    end
`endif
  end

  assign add_s = {1'b0, add_a} + {1'b0, (add_ci ? ~add_b : add_b)} + {8'd0, add_ci};

  always_comb begin
    mul_part = mq_q[0] ? add_s : {1'b0, acc_q};
    step_acc = mul_part[8:1];
    step_mq  = {mul_part[0], mq_q[7:1]};
`ifdef DIV_EN
    // Restoring step: keep the trial difference when R' >= D
    if (op_q) begin
      if (acc_q[7] || add_s[8]) begin
        step_acc = add_s[7:0];
        step_mq  = {mq_q[6:0], 1'b1};
      end else begin
        step_acc = r_shift;
        step_mq  = {mq_q[6:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    m_d      = m_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;
`ifdef DIV_EN
    op_d     = op_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 8'd0;
          count_d = 3'd0;
          dbz_d   = 1'b0;
          mq_d    = b;
          m_d     = a;
`ifdef DIV_EN
          op_d    = op;
          if (op) begin
            mq_d = a;
            m_d  = b;
          end
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Zero divisor leaves after one RUN cycle with saturated quotient
        if (div_zero) begin
          res_hi_d = mq_q;
          res_lo_d = 8'hFF;
          dbz_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          acc_d   = step_acc;
          mq_d    = step_mq;
          count_d = count_q + 3'd1;
          if (count_q == 3'd7) begin
            res_hi_d = step_acc;
            res_lo_d = step_mq;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 3'd0;
      acc_q    <= 8'd0;
      mq_q     <= 8'd0;
      m_q      <= 8'd0;
      res_hi_q <= 8'd0;
      res_lo_q <= 8'd0;
      dbz_q    <= 1'b0;
`ifdef DIV_EN
      op_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      m_q      <= m_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
`ifdef DIV_EN
      op_q     <= op_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;
  assign dbz       = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_ctrl.sv
`default_nettype none
// Scoreboard bench for muldiv_seq_ctrl; divide cases build only with DIV_EN.
module tb_muldiv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, op;
  logic [7:0] a, b;
  logic       busy, done, dbz;
  logic [7:0] result_hi, result_lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  muldiv_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference result; 'now' is the cycle count at the negedge start is driven
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic iop, input int now);
    exp_t        e;
    logic [15:0] p;
    e.dbz = 1'b0;
    e.cyc = now + 9;
`ifdef DIV_EN
    if (iop) begin
      if (ib == 8'd0) begin
        e.hi  = ia;
        e.lo  = 8'hFF;
        e.dbz = 1'b1;
        e.cyc = now + 2;
      end else begin
        e.lo = ia / ib;
        e.hi = ia % ib;
      end
      return e;
    end
`else
    if (iop) e.dbz = 1'b0;
`endif
    p    = 16'(ia) * 16'(ib);
    e.hi = p[15:8];
    e.lo = p[7:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("result_hi", 32'(result_hi), 32'(mon_e.hi));
        check_val("result_lo", 32'(result_lo), 32'(mon_e.lo));
        check_val("dbz",       32'(dbz),       32'(mon_e.dbz));
        check_val("done_cycle", 32'(cyc),      32'(mon_e.cyc));
      end
    end
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic iop);
    a     = ia;
    b     = ib;
    op    = iop;
    start = 1'b1;
    sb.push_back(model(ia, ib, iop, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 32'((sb.size() == 0) && !busy), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = 8'd0; b = 8'd0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_hi",   32'(result_hi), 32'd0);
    check_val("rst_lo",   32'(result_lo), 32'd0);
    check_val("rst_dbz",  32'(dbz), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'd13, 8'd11, 1'b0);  wait_idle();
    issue(8'd255, 8'd255, 1'b0); wait_idle();
    issue(8'd0, 8'd200, 1'b0);  wait_idle();

    // Second start at k+3 must be ignored
    issue(8'd9, 8'd10, 1'b0);
    check_val("busy_run", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    a = 8'd77; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held high: accepted only in IDLE, done every 10 cycles
    n0 = cyc;
    a = 8'd17; b = 8'd15; op = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(8'd17, 8'd15, 1'b0, n0 + 10 * i));
    repeat (22) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset at edge k+4 of a multiply
    issue(8'd50, 8'd5, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_hi",   32'(result_hi), 32'd0);
    check_val("abort_lo",   32'(result_lo), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'd100, 8'd3, 1'b0); wait_idle();

`ifdef DIV_EN
    issue(8'd200, 8'd7, 1'b1); wait_idle();
    issue(8'd5, 8'd9, 1'b1);   wait_idle();
    issue(8'd255, 8'd1, 1'b1); wait_idle();
    issue(8'd42, 8'd0, 1'b1);  wait_idle();
    issue(8'd200, 8'd7, 1'b1); wait_idle();
`else
    issue(8'd6, 8'd7, 1'b1);   wait_idle();
`endif

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
